thirtytwo_bitdivider: RTL and testbench

//  Sequential unsigned divider, the inverse datapath to the ripple adders: quotient and remainder of dividend/divisor.

---
 rtl/thirtytwo_bitdivider_pkg.sv | 13 +
 rtl/thirtytwo_bitdivider_if.sv | 21 ++
 rtl/thirtytwo_bitdivider_subtractor.sv | 41 ++++
 rtl/thirtytwo_bitdivider.sv | 103 ++++++++++
 tb/tb_thirtytwo_bitdivider.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/thirtytwo_bitdivider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// the quotient reported on divide-by-zero.
package thirtytwo_bitdivider_pkg;
  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [DEF_WIDTH-1:0] DIV_ZERO_Q = {DEF_WIDTH{1'b1}};
endpackage

// File: rtl/thirtytwo_bitdivider_if.sv
// Start/done handshake and operand/result bus of the divider.
interface thirtytwo_bitdivider_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/thirtytwo_bitdivider_subtractor.sv
// Ripple-carry adder and the subtractor built on it (a + ~b + c_in).
// c_out=1 from the subtractor means no borrow when c_in=1.
module thirtytwo_bitadder #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c_in,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_c_out
);
  logic w_c;

  always_comb begin
    w_c   = i_c_in;
    o_sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_c_out = w_c;
  end
endmodule

module thirtytwo_bitsubtractor #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c_in,
  output logic             o_c_out,
  output logic [WIDTH-1:0] o_diff
);
  logic [WIDTH-1:0] w_b_n;

  assign w_b_n = ~i_b;

  thirtytwo_bitadder #(.WIDTH(WIDTH)) u_add (
    .i_a     (i_a),
    .i_b     (w_b_n),
    .i_c_in  (i_c_in),
    .o_sum   (o_diff),
    .o_c_out (o_c_out)
  );
endmodule

// File: rtl/thirtytwo_bitdivider.sv
// Restoring unsigned divider: one quotient bit per clock, WIDTH RUN cycles,
// divide-by-zero short-circuits straight to DONE.
module thirtytwo_bitdivider
  import thirtytwo_bitdivider_pkg::*;
#(parameter int WIDTH = DEF_WIDTH) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  thirtytwo_bitdivider_if.slave bus
);
  state_t           r_state;
  logic [5:0]       r_count;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic [WIDTH:0]   w_r_sh;
  logic [WIDTH-1:0] w_diff;
  logic             w_c_out;
  logic             w_no_borrow;
  logic [WIDTH:0]   w_r_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_last;

  assign w_r_sh = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};

  thirtytwo_bitsubtractor #(.WIDTH(WIDTH)) u_sub (
    .i_a     (w_r_sh[WIDTH-1:0]),
    .i_b     (r_d),
    .i_c_in  (1'b1),
    .o_c_out (w_c_out),
    .o_diff  (w_diff)
  );

  // The shifted-out top bit of R means R >= 2^WIDTH > D, so the trial always fits.
  assign w_no_borrow = w_r_sh[WIDTH] | w_c_out;
  assign w_r_next    = w_no_borrow ? {1'b0, w_diff} : w_r_sh;
  assign w_q_next    = {r_q[WIDTH-2:0], w_no_borrow};
  assign w_last      = (r_count == 6'(WIDTH-1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_RUN: begin
          r_rem   <= w_r_next;
          r_q     <= w_q_next;
          r_count <= r_count + 6'd1;
          if (w_last) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_quotient  <= w_q_next;
            r_remainder <= w_r_next[WIDTH-1:0];
            r_dbz       <= 1'b0;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request; DONE lasts one cycle.
          if (bus.start) begin
            if (bus.divisor == '0) begin
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_quotient  <= WIDTH'(DIV_ZERO_Q);
              r_remainder <= bus.dividend;
              r_dbz       <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_q     <= bus.dividend;
              r_rem   <= '0;
              r_d     <= bus.divisor;
              r_count <= '0;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_thirtytwo_bitdivider.sv
// Self-checking bench: directed corner cases plus random operands compared
// against plain '/' and '%' arithmetic.
module tb_thirtytwo_bitdivider;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  thirtytwo_bitdivider_if #(.WIDTH(W)) bus();

  thirtytwo_bitdivider #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle start pulse; operands are scrambled afterwards so late sampling shows up.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    tick();
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
  endtask

  // cyc counts rising edges with the accepting edge as 1; bounded wait.
  task automatic wait_done(input int c0, output int cyc, output int bsy);
    cyc = c0;
    bsy = 0;
    while (bus.done !== 1'b1 && cyc < 200) begin
      if (bus.busy === 1'b1) bsy++;
      tick();
      cyc++;
    end
  endtask

  task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endtask

  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q, r;
    logic         z;
    int           cyc, bsy;
    ref_div(a, b, q, r, z);
    launch(a, b);
    wait_done(1, cyc, bsy);
    chk({tag, " latency"}, W'(cyc), (b == 0) ? W'(1) : W'(W + 1));
    chk({tag, " busy cycles"}, W'(bsy), (b == 0) ? W'(0) : W'(W));
    chk({tag, " quotient"}, bus.quotient, q);
    chk({tag, " remainder"}, bus.remainder, r);
    chk({tag, " div_by_zero"}, W'(bus.div_by_zero), W'(z));
    tick();
    chk({tag, " done pulse width"}, W'(bus.done), W'(0));
    chk({tag, " quotient held"}, bus.quotient, q);
  endtask

  initial begin
    int cyc, bsy, seen;
    logic [W-1:0] a, b;

    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    tick(); tick();
    chk("reset busy", W'(bus.busy), W'(0));
    chk("reset done", W'(bus.done), W'(0));
    chk("reset quotient", bus.quotient, W'(0));
    chk("reset remainder", bus.remainder, W'(0));
    chk("reset div_by_zero", W'(bus.div_by_zero), W'(0));

    // start during reset is dropped
    bus.start = 1'b1; bus.dividend = 100; bus.divisor = 7;
    tick();
    bus.start = 1'b0; reset = 1'b0;
    chk("reset+start busy", W'(bus.busy), W'(0));
    tick();
    chk("reset+start dropped", W'(bus.busy), W'(0));

    run_div("100/7", 100, 7);
    chk("100/7 quotient const", bus.quotient, W'(14));
    chk("100/7 remainder const", bus.remainder, W'(2));
    run_div("max/1", 32'hFFFF_FFFF, 1);
    run_div("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_div("3/10", 3, 10);
    run_div("0/5", 0, 5);
    run_div("5/0", 5, 0);
    chk("5/0 quotient const", bus.quotient, 32'hFFFF_FFFF);

    // start during RUN is ignored, then back-to-back start in the DONE cycle
    launch(1000, 3);
    repeat (8) tick();
    bus.start = 1'b1; bus.dividend = 8; bus.divisor = 2;
    tick();
    bus.start = 1'b0;
    chk("ignored start busy", W'(bus.busy), W'(1));
    wait_done(10, cyc, bsy);
    chk("1000/3 latency", W'(cyc), W'(W + 1));
    chk("1000/3 quotient", bus.quotient, W'(333));
    chk("1000/3 remainder", bus.remainder, W'(1));
    bus.start = 1'b1; bus.dividend = 8; bus.divisor = 2;
    tick();
    bus.start = 1'b0;
    chk("b2b done low", W'(bus.done), W'(0));
    chk("b2b busy", W'(bus.busy), W'(1));
    chk("b2b result held", bus.quotient, W'(333));
    wait_done(1, cyc, bsy);
    chk("8/2 latency", W'(cyc), W'(W + 1));
    chk("8/2 quotient", bus.quotient, W'(4));
    chk("8/2 remainder", bus.remainder, W'(0));
    tick();

    // reset mid-RUN discards the in-flight result
    launch(1000, 3);
    repeat (14) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset busy", W'(bus.busy), W'(0));
    chk("midreset done", W'(bus.done), W'(0));
    chk("midreset quotient", bus.quotient, W'(0));
    chk("midreset remainder", bus.remainder, W'(0));
    chk("midreset div_by_zero", W'(bus.div_by_zero), W'(0));
    seen = 0;
    repeat (40) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
      tick();
    end
    chk("midreset no done", W'(seen), W'(0));

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      if (i % 6 == 5)      b = 0;
      else if (i % 4 == 0) b = $urandom_range(1, 15);
      else if (i % 4 == 1) b = a + $urandom_range(0, 100);
      else                 b = $urandom >> $urandom_range(0, 31);
      if (b == 0 && i % 6 != 5) b = 1;
      run_div($sformatf("rand%0d", i), a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
